// File: rtl/regfile_2r2w_sweep_if.sv
// Register file port bundle: two write ports, two read ports, clear control.
// master = requester side, slave = register file side.
interface regfile_2r2w_sweep_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we_a;
  logic [ADDR_W-1:0] waddr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              we_b;
  logic [ADDR_W-1:0] waddr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic              rvalid_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rvalid_b;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output we_a, waddr_a, wdata_a,
    output we_b, waddr_b, wdata_b,
    output re_a, raddr_a,
    output re_b, raddr_b,
    output clr_req,
    input  rdata_a, rvalid_a,
    input  rdata_b, rvalid_b,
    input  clr_busy, clr_done
  );

  modport slave (
    input  we_a, waddr_a, wdata_a,
    input  we_b, waddr_b, wdata_b,
    input  re_a, raddr_a,
    input  re_b, raddr_b,
    input  clr_req,
    output rdata_a, rvalid_a,
    output rdata_b, rvalid_b,
    output clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_2r2w_sweep.sv
// 2-write/2-read register bank with a multi-cycle clear sweep engine.
// Optional macro REGFILE_WR_BYPASS_EN: same-edge write data forwarded to reads.
module regfile_2r2w_sweep #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RST_VAL0 = 32'h0000_FFFF,
  parameter logic [31:0] RST_VAL1 = 32'hFFFF_0000,
  parameter bit          ZERO_REG = 1'b0
) (
  input logic                 clk,
  input logic                 Reset,
  regfile_2r2w_sweep_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [DATA_W-1:0] INIT0 =
    ZERO_REG ? {DATA_W{1'b0}} : DATA_W'(RST_VAL0);
  localparam logic [DATA_W-1:0] INIT1 = DATA_W'(RST_VAL1);
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic              r_rvalid_a;
  logic              r_rvalid_b;

  logic              w_busy;
  logic              w_sweep_we;
  logic              w_wa_en;
  logic              w_wb_en;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  function automatic logic [DATA_W-1:0] f_init(
    input logic [ADDR_W-1:0] idx
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (idx == ADDR_W'(0))
      v = INIT0;
    else if (idx == ADDR_W'(1))
      v = INIT1;
    return v;
  endfunction

  assign w_busy     = (r_state != S_IDLE);
  assign w_sweep_we = (r_state == S_SWEEP);

  // User writes are dropped while the sweep owns the array.
  assign w_wa_en = bus.we_a & ~w_busy &
                   ~(ZERO_REG & (bus.waddr_a == '0));
  assign w_wb_en = bus.we_b & ~w_busy &
                   ~(ZERO_REG & (bus.waddr_b == '0));

  // Clear FSM state and sweep pointer register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Clear FSM next state; pointer parks on the last entry, no wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt = S_SWEEP;
          w_ptr_nxt   = '0;
        end
      end
      S_SWEEP: begin
        if (r_ptr == PTR_LAST)
          w_state_nxt = S_DONE;
        else
          w_ptr_nxt = r_ptr + ADDR_W'(1);
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Array update: sweep, else port A then port B so B wins a collision.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= f_init(ADDR_W'(i));
    end else if (w_sweep_we) begin
      r_mem[r_ptr] <= f_init(r_ptr);
    end else begin
      if (w_wa_en)
        r_mem[bus.waddr_a] <= bus.wdata_a;
      if (w_wb_en)
        r_mem[bus.waddr_b] <= bus.wdata_b;
    end
  end

  // Read port A data select.
  always_comb begin
    w_rd_a = r_mem[bus.raddr_a];
`ifdef REGFILE_WR_BYPASS_EN
    if (w_wb_en && (bus.waddr_b == bus.raddr_a))
      w_rd_a = bus.wdata_b;
    else if (w_wa_en && (bus.waddr_a == bus.raddr_a))
      w_rd_a = bus.wdata_a;
`endif
    if (ZERO_REG && (bus.raddr_a == '0))
      w_rd_a = '0;
  end

  // Read port B data select.
  always_comb begin
    w_rd_b = r_mem[bus.raddr_b];
`ifdef REGFILE_WR_BYPASS_EN
    if (w_wb_en && (bus.waddr_b == bus.raddr_b))
      w_rd_b = bus.wdata_b;
    else if (w_wa_en && (bus.waddr_a == bus.raddr_b))
      w_rd_b = bus.wdata_a;
`endif
    if (ZERO_REG && (bus.raddr_b == '0))
      w_rd_b = '0;
  end

  // Registered read ports; data holds when not enabled.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_a <= bus.re_a;
      r_rvalid_b <= bus.re_b;
      if (bus.re_a)
        r_rdata_a <= w_rd_a;
      if (bus.re_b)
        r_rdata_b <= w_rd_b;
    end
  end

  assign bus.rdata_a  = r_rdata_a;
  assign bus.rdata_b  = r_rdata_b;
  assign bus.rvalid_a = r_rvalid_a;
  assign bus.rvalid_b = r_rvalid_b;
  assign bus.clr_busy = w_busy;
  assign bus.clr_done = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_2r2w_sweep.sv
// Directed bench for regfile_2r2w_sweep (default and ZERO_REG builds).
// Expected values are hand-computed constants.
module tb_regfile_2r2w_sweep;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic Reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   nbusy;
  int   ndone;
  bit   ok;

  regfile_2r2w_sweep_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
  regfile_2r2w_sweep_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

  regfile_2r2w_sweep #(
    .DATA_W(32), .ADDR_W(5),
    .RST_VAL0(32'h0000_FFFF), .RST_VAL1(32'hFFFF_0000),
    .ZERO_REG(1'b0)
  ) u_dut (
    .clk(clk), .Reset(Reset), .bus(bus0)
  );

  regfile_2r2w_sweep #(
    .DATA_W(32), .ADDR_W(5),
    .RST_VAL0(32'h0000_FFFF), .RST_VAL1(32'hFFFF_0000),
    .ZERO_REG(1'b1)
  ) u_dutz (
    .clk(clk), .Reset(Reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    bus0.we_a = 0; bus0.waddr_a = '0; bus0.wdata_a = '0;
    bus0.we_b = 0; bus0.waddr_b = '0; bus0.wdata_b = '0;
    bus0.re_a = 0; bus0.raddr_a = '0;
    bus0.re_b = 0; bus0.raddr_b = '0;
    bus0.clr_req = 0;
    bus1.we_a = 0; bus1.waddr_a = '0; bus1.wdata_a = '0;
    bus1.we_b = 0; bus1.waddr_b = '0; bus1.wdata_b = '0;
    bus1.re_a = 0; bus1.raddr_a = '0;
    bus1.re_b = 0; bus1.raddr_b = '0;
    bus1.clr_req = 0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    bus0.we_a = 1; bus0.waddr_a = a; bus0.wdata_a = d;
    tick;
    bus0.we_a = 0;
  endtask

  task automatic rd0(input string tag, input logic [4:0] a,
                     input logic [31:0] exp);
    bus0.re_a = 1; bus0.raddr_a = a;
    tick;
    bus0.re_a = 0;
    chk(tag, bus0.rdata_a, exp);
    chk({tag, "_vld"}, {31'd0, bus0.rvalid_a}, 32'd1);
  endtask

  task automatic rd1(input string tag, input logic [4:0] a,
                     input logic [31:0] exp);
    bus1.re_a = 1; bus1.raddr_a = a;
    tick;
    bus1.re_a = 0;
    chk(tag, bus1.rdata_a, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    idle_all();
    tick;
    tick;
    chk("rst_rdata_a", bus0.rdata_a, 32'h0);
    chk("rst_rdata_b", bus0.rdata_b, 32'h0);
    chk("rst_rvalid_a", {31'd0, bus0.rvalid_a}, 32'd0);
    chk("rst_busy", {31'd0, bus0.clr_busy}, 32'd0);
    chk("rst_done", {31'd0, bus0.clr_done}, 32'd0);
    Reset = 1'b0;
    tick;

    // Reset values through both read ports.
    bus0.re_a = 1; bus0.raddr_a = 5'd0;
    bus0.re_b = 1; bus0.raddr_b = 5'd1;
    tick;
    bus0.re_a = 0; bus0.re_b = 0;
    chk("init0_a", bus0.rdata_a, 32'h0000_FFFF);
    chk("init1_b", bus0.rdata_b, 32'hFFFF_0000);
    chk("init_vld_a", {31'd0, bus0.rvalid_a}, 32'd1);
    chk("init_vld_b", {31'd0, bus0.rvalid_b}, 32'd1);
    tick;
    chk("hold_vld_a", {31'd0, bus0.rvalid_a}, 32'd0);
    chk("hold_vld_b", {31'd0, bus0.rvalid_b}, 32'd0);
    chk("hold_data_a", bus0.rdata_a, 32'h0000_FFFF);
    rd0("init5", 5'd5, 32'h0);

    // Same-address collision: port B wins.
    bus0.we_a = 1; bus0.waddr_a = 5'd3; bus0.wdata_a = 32'h1111_1111;
    bus0.we_b = 1; bus0.waddr_b = 5'd3; bus0.wdata_b = 32'h2222_2222;
    tick;
    bus0.we_a = 0; bus0.we_b = 0;
    bus0.re_b = 1; bus0.raddr_b = 5'd3;
    tick;
    bus0.re_b = 0;
    chk("collide_b", bus0.rdata_b, 32'h2222_2222);

    // Read during same-edge write.
    bus0.we_a = 1; bus0.waddr_a = 5'd7; bus0.wdata_a = 32'hDEAD_BEEF;
    bus0.re_a = 1; bus0.raddr_a = 5'd7;
    tick;
    bus0.we_a = 0; bus0.re_a = 0;
    chk("rw_same", bus0.rdata_a, BYP ? 32'hDEAD_BEEF : 32'h0);
    rd0("rw_after", 5'd7, 32'hDEAD_BEEF);

    // Fill, then sweep.
    for (int i = 0; i < 32; i++)
      wr0(5'(i), 32'hA5A5_A5A5);
    rd0("fill31", 5'd31, 32'hA5A5_A5A5);
    rd0("fill0", 5'd0, 32'hA5A5_A5A5);

    bus0.clr_req = 1;
    tick;
    bus0.clr_req = 0;
    nbusy = 0;
    ndone = 0;
    for (int c = 0; c < 100; c++) begin
      if (!bus0.clr_busy) break;
      nbusy++;
      if (bus0.clr_done) ndone++;
      bus0.we_a    = (c == 20);
      bus0.waddr_a = 5'd9;
      bus0.wdata_a = 32'h1234_5678;
      tick;
    end
    bus0.we_a = 0;
    chk("busy_cycles", nbusy, 32'd33);
    chk("done_pulses", ndone, 32'd1);
    rd0("swp0", 5'd0, 32'h0000_FFFF);
    rd0("swp1", 5'd1, 32'hFFFF_0000);
    rd0("swp31", 5'd31, 32'h0);
    rd0("swp9_drop", 5'd9, 32'h0);

    // Reset in the middle of a sweep.
    wr0(5'd20, 32'h5555_5555);
    bus0.clr_req = 1;
    tick;
    bus0.clr_req = 0;
    for (int c = 0; c < 10; c++)
      tick;
    chk("mid_busy", {31'd0, bus0.clr_busy}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus0.clr_busy}, 32'd0);
    chk("abort_done", {31'd0, bus0.clr_done}, 32'd0);
    tick;
    Reset = 1'b0;
    tick;
    chk("post_busy", {31'd0, bus0.clr_busy}, 32'd0);
    chk("post_done", {31'd0, bus0.clr_done}, 32'd0);
    rd0("abort20", 5'd20, 32'h0);
    rd0("abort0", 5'd0, 32'h0000_FFFF);
    rd0("abort1", 5'd1, 32'hFFFF_0000);

    // clr_req held through DONE restarts after one IDLE cycle.
    bus0.clr_req = 1;
    tick;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus0.clr_done) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
    chk("hold_done_seen", {31'd0, ok}, 32'd1);
    tick;
    chk("hold_idle", {31'd0, bus0.clr_busy}, 32'd0);
    tick;
    bus0.clr_req = 0;
    chk("hold_restart", {31'd0, bus0.clr_busy}, 32'd1);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!bus0.clr_busy) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
    chk("restart_end", {31'd0, ok}, 32'd1);

    // Hard-wired zero entry.
    rd1("z_init0", 5'd0, 32'h0);
    rd1("z_init1", 5'd1, 32'hFFFF_0000);
    bus1.we_a = 1; bus1.waddr_a = 5'd0; bus1.wdata_a = 32'hFFFF_FFFF;
    bus1.we_b = 1; bus1.waddr_b = 5'd2; bus1.wdata_b = 32'h0BAD_CAFE;
    bus1.re_b = 1; bus1.raddr_b = 5'd0;
    tick;
    bus1.we_a = 0; bus1.we_b = 0; bus1.re_b = 0;
    chk("z_rw0", bus1.rdata_b, 32'h0);
    rd1("z_wr0", 5'd0, 32'h0);
    rd1("z_wr2", 5'd2, 32'h0BAD_CAFE);
    bus1.clr_req = 1;
    tick;
    bus1.clr_req = 0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!bus1.clr_busy) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
    chk("z_swp_end", {31'd0, ok}, 32'd1);
    rd1("z_swp0", 5'd0, 32'h0);
    rd1("z_swp2", 5'd2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
